vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scan-out engine, the successor to the fixed 640x480 framebuffer driver. It generates horizontal and vertical timing from clk50 with configurable porches, sync widths, sync polarities and clock divide ratio. Pixel requests run a configurable number of pixel periods ahead of the display, which hides the read latency of the pixel source. An optional integer pixel-doubling mode is included. It sits between the frame memory or sprite compositor and the board VGA DAC pins.

## Interface
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch, pixels
- HSYNC, 96, horizontal sync width, pixels
- HBP, 48, horizontal back porch, pixels
- VACTIVE, 480, visible lines per frame
- VFP, 10, vertical front porch, lines
- VSYNC, 2, vertical sync width, lines
- VBP, 33, vertical back porch, lines
- HS_POL, 0, active level of VGA_HS (0 = active-low)
- VS_POL, 0, active level of VGA_VS
- CLKDIV, 2, clk50 cycles per pixel; even, at least 2
- READ_LATENCY, 2, pixel periods from a request to its r/g/b being sampled; must be less than HTOTAL
- SCALE_SHIFT, 0, 0 = 1:1 scan-out, 1 = 2x2 pixel doubling
- clk50 input 1: system clock, all logic on its rising edge
- reset input 1: reset, synchronous, active-high; clock clk50
- r, g, b input 8 each: pixel colour answering the request issued READ_LATENCY pixels earlier
- request_x output $clog2(HACTIVE): requested column, already scaled
- request_y output $clog2(VACTIVE): requested row, already scaled
- request_valid output 1: request position lies inside the active area
- frame_start output 1: one-cycle pulse when the display position moves to (0,0)
- line_start output 1: one-cycle pulse when the display position moves to column 0
- VGA_R, VGA_G, VGA_B output 8 each: DAC colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n output 1 each: DAC and connector controls

## Operation
- Derived totals: HTOTAL = HACTIVE+HFP+HSYNC+HBP and VTOTAL = VACTIVE+VFP+VSYNC+VBP. With the defaults these are 800 and 525.
- Divider: divcnt counts 0..CLKDIV-1 and wraps. tick = (divcnt == CLKDIV-1).
- Display counters hcnt (0..HTOTAL-1) and vcnt (0..VTOTAL-1) advance on tick.
  - hcnt wraps to 0 at HTOTAL-1.
  - vcnt increments only when hcnt wraps, and wraps to 0 at VTOTAL-1.
- Request counters hreq and vreq use the same wrap rules and always lead the display by exactly READ_LATENCY pixel positions, modulo the frame.
- request_valid = (hreq < HACTIVE) and (vreq < VACTIVE).
- request_x = hreq >> SCALE_SHIFT and request_y = vreq >> SCALE_SHIFT when valid; both are 0 when invalid.
- Output stage: on each tick, register the current (hcnt, vcnt) pixel into the outputs.
  - VGA_R/G/B = r/g/b when hcnt < HACTIVE and vcnt < VACTIVE, else 0.
  - VGA_BLANK_n = 1 inside the active area, else 0.
  - VGA_HS = HS_POL when hcnt is in [HACTIVE+HFP, HACTIVE+HFP+HSYNC), else ~HS_POL.
  - VGA_VS = VS_POL when vcnt is in [VACTIVE+VFP, VACTIVE+VFP+VSYNC), for whole lines; else ~VS_POL.
- VGA_CLK = 1 when divcnt >= CLKDIV/2. Its rising edge falls mid-way through each stable output period.
- VGA_SYNC_n is held at 1.
- line_start is asserted for the single clk50 cycle after a tick that wrapped hcnt to 0. frame_start is asserted likewise when both hcnt and vcnt wrapped.

## Timing
- Reset values:
  - divcnt = 0, hcnt = vcnt = 0.
  - hreq = READ_LATENCY, vreq = 0.
  - VGA_R/G/B = 0, VGA_BLANK_n = 0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - VGA_CLK = 0, VGA_SYNC_n = 1.
  - line_start = frame_start = 0.
- Reset asserted mid-frame returns all state to these values on the next edge. No partial line is emitted.
- First tick falls at clk50 cycle CLKDIV-1 after reset deasserts, counting the first cycle with reset low as cycle 0.
- request_x, request_y and request_valid are registered and change one cycle after a tick.
- r/g/b are sampled on the tick edge of pixel P. They must answer the request for P, which was presented READ_LATENCY pixel periods (READ_LATENCY*CLKDIV cycles) earlier.
- With READ_LATENCY = 0, the request equals the display position, so the source must be combinational.
- Pixel-to-DAC latency is 1 tick: pixel P appears on the outputs during P's successor period.
- Line period is HTOTAL*CLKDIV cycles. Frame period is VTOTAL line periods; with the defaults, 1600 and 840000 cycles.
- With SCALE_SHIFT = 1, each request coordinate repeats for 2 consecutive columns and 2 consecutive lines.

## Test plan
- Defaults, reset then run 2 frames: line_start every 1600 cycles, frame_start every 840000 cycles. VGA_HS low for 192 cycles starting at hcnt 656. VGA_VS low for lines 490-491.
- Defaults with a model RAM of latency 2 returning r=x[7:0], g=y[7:0], b=0x55: every active DAC pixel equals its own coordinates. Blanking pixels give 0 and BLANK_n=0.
- READ_LATENCY=5: at display (0,0), the request is (5,0). At display (795,524), the request is (0,0) with request_valid=1.
- SCALE_SHIFT=1: request_x sequence 0,0,1,1,...,319,319. request_y holds 0 for lines 0-1 and reaches 239 on lines 478-479.
- CLKDIV=4, HS_POL=1, VS_POL=1, 800x600 timing (40/128/88, 1/4/23): HS high for 512 cycles per line, VGA_CLK has period 4 and is high on divcnt 2-3, frame = 628 lines.
- Reset pulsed at an arbitrary mid-frame cycle: the next cycle shows all reset values. Timing then restarts so that the first frame_start arrives 840000 cycles later.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Pixel request bus between the scan-out engine and its pixel source.
// The engine issues (request_x, request_y, request_valid) and the source
// answers on r/g/b a fixed number of pixel periods later.
interface vga_scanout_if #(
  parameter int XW = 10,
  parameter int YW = 9
) ();
  logic [XW-1:0] request_x;
  logic [YW-1:0] request_y;
  logic          request_valid;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;

  modport master (output request_x, request_y, request_valid, input r, g, b);
  modport slave  (input request_x, request_y, request_valid, output r, g, b);
endinterface

// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out engine: pixel clock divider, display and
// look-ahead request counters, registered DAC/sync outputs.
module vga_scanout #(
  parameter int HACTIVE      = 640,
  parameter int HFP          = 16,
  parameter int HSYNC        = 96,
  parameter int HBP          = 48,
  parameter int VACTIVE      = 480,
  parameter int VFP          = 10,
  parameter int VSYNC        = 2,
  parameter int VBP          = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int CLKDIV       = 2,
  parameter int READ_LATENCY = 2,
  parameter int SCALE_SHIFT  = 0
) (
  input  logic             clk50,
  input  logic             reset,
  vga_scanout_if.master    pix,
  output logic             frame_start,
  output logic             line_start,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_n,
  output logic             VGA_SYNC_n
);
  localparam int HTOTAL   = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL   = VACTIVE + VFP + VSYNC + VBP;
  localparam int HW       = $clog2(HTOTAL);
  localparam int VW       = $clog2(VTOTAL);
  localparam int DW       = $clog2(CLKDIV);
  localparam int XW       = $clog2(HACTIVE);
  localparam int YW       = $clog2(VACTIVE);
  localparam int HS_START = HACTIVE + HFP;
  localparam int HS_END   = HS_START + HSYNC;
  localparam int VS_START = VACTIVE + VFP;
  localparam int VS_END   = VS_START + VSYNC;

  logic [DW-1:0] divcnt_reg, divcnt_next;
  logic [HW-1:0] hcnt_reg, hcnt_next, hreq_reg, hreq_next;
  logic [VW-1:0] vcnt_reg, vcnt_next, vreq_reg, vreq_next;
  logic          tick;
  logic          hcnt_wrap, vcnt_wrap, hreq_wrap, vreq_wrap;
  logic          disp_active, req_active, hs_zone, vs_zone;
  logic [7:0]    src_rgb [3];
  logic [7:0]    dac_reg [3];

  // Next-state for divider and both counter pairs; request pair shares the display wrap rules.
  always_comb begin
    tick        = (divcnt_reg == DW'(CLKDIV - 1));
    divcnt_next = tick ? '0 : divcnt_reg + DW'(1);
    hcnt_wrap   = (hcnt_reg == HW'(HTOTAL - 1));
    vcnt_wrap   = (vcnt_reg == VW'(VTOTAL - 1));
    hreq_wrap   = (hreq_reg == HW'(HTOTAL - 1));
    vreq_wrap   = (vreq_reg == VW'(VTOTAL - 1));
    hcnt_next   = hcnt_reg;
    vcnt_next   = vcnt_reg;
    hreq_next   = hreq_reg;
    vreq_next   = vreq_reg;
    if (tick) begin
      hcnt_next = hcnt_wrap ? '0 : hcnt_reg + HW'(1);
      hreq_next = hreq_wrap ? '0 : hreq_reg + HW'(1);
      if (hcnt_wrap) vcnt_next = vcnt_wrap ? '0 : vcnt_reg + VW'(1);
      if (hreq_wrap) vreq_next = vreq_wrap ? '0 : vreq_reg + VW'(1);
    end
    disp_active = (int'(hcnt_reg) < HACTIVE) && (int'(vcnt_reg) < VACTIVE);
    req_active  = (int'(hreq_reg) < HACTIVE) && (int'(vreq_reg) < VACTIVE);
    hs_zone     = (int'(hcnt_reg) >= HS_START) && (int'(hcnt_reg) < HS_END);
    vs_zone     = (int'(vcnt_reg) >= VS_START) && (int'(vcnt_reg) < VS_END);
  end

  // Divider and counters; the request counters start READ_LATENCY pixels ahead.
  always_ff @(posedge clk50) begin
    if (reset) begin
      divcnt_reg <= '0;
      hcnt_reg   <= '0;
      vcnt_reg   <= '0;
      hreq_reg   <= HW'(READ_LATENCY);
      vreq_reg   <= '0;
    end else begin
      divcnt_reg <= divcnt_next;
      hcnt_reg   <= hcnt_next;
      vcnt_reg   <= vcnt_next;
      hreq_reg   <= hreq_next;
      vreq_reg   <= vreq_next;
    end
  end

  // Registered request bus; coordinates are forced to 0 outside the active area.
  always_ff @(posedge clk50) begin
    if (reset) begin
      pix.request_x     <= '0;
      pix.request_y     <= '0;
      pix.request_valid <= 1'b0;
    end else begin
      pix.request_valid <= req_active;
      pix.request_x     <= req_active ? XW'(hreq_reg >> SCALE_SHIFT) : '0;
      pix.request_y     <= req_active ? YW'(vreq_reg >> SCALE_SHIFT) : '0;
    end
  end

  assign src_rgb[0] = pix.r;
  assign src_rgb[1] = pix.g;
  assign src_rgb[2] = pix.b;

  // One DAC channel per colour: capture the source on the tick that ends each pixel.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dac
    always_ff @(posedge clk50) begin
      if (reset)     dac_reg[gi] <= '0;
      else if (tick) dac_reg[gi] <= disp_active ? src_rgb[gi] : '0;
    end
  end

  assign VGA_R      = dac_reg[0];
  assign VGA_G      = dac_reg[1];
  assign VGA_B      = dac_reg[2];
  assign VGA_SYNC_n = 1'b1;

  // Blank/sync follow the pixel just ended; VGA_CLK rises half-way through each pixel.
  always_ff @(posedge clk50) begin
    if (reset) begin
      VGA_BLANK_n <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_CLK     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_CLK     <= (int'(divcnt_next) >= CLKDIV / 2);
      line_start  <= tick && hcnt_wrap;
      frame_start <= tick && hcnt_wrap && vcnt_wrap;
      if (tick) begin
        VGA_BLANK_n <= disp_active;
        VGA_HS      <= hs_zone ? HS_POL : ~HS_POL;
        VGA_VS      <= vs_zone ? VS_POL : ~VS_POL;
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two small-timing instances (1:1 and doubled,
// opposite polarities, different divide and latency), each fed by a
// delay-line pixel source; expectations are queued per clk50 edge and
// compared on the following falling edge.
module tb_vga_scanout;
  localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 3;
  localparam int A_VA = 8,  A_VFP = 1, A_VS = 2, A_VBP = 2;
  localparam int A_CD = 2,  A_RL = 2,  A_SS = 0;
  localparam bit A_HP = 1'b0, A_VP = 1'b0;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_FR = A_HT * (A_VA + A_VFP + A_VS + A_VBP);
  localparam int A_N  = A_RL * A_CD;

  localparam int B_HA = 16, B_HFP = 1, B_HS = 4, B_HBP = 3;
  localparam int B_VA = 8,  B_VFP = 1, B_VS = 1, B_VBP = 2;
  localparam int B_CD = 4,  B_RL = 5,  B_SS = 1;
  localparam bit B_HP = 1'b1, B_VP = 1'b1;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_FR = B_HT * (B_VA + B_VFP + B_VS + B_VBP);
  localparam int B_N  = B_RL * B_CD;

  typedef struct {
    bit         chk_rgb;
    bit         chk_req;
    logic [7:0] r, g, b;
    logic       blank, hs, vs, vclk, ls, fs, rv;
    int         rx, ry;
  } exp_t;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  always #5 clk50 = ~clk50;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // Independent timing model: what the outputs show just after clk50 edge e
  // (e counted from 0 at the first edge with reset low).
  function automatic exp_t model(input int e, input bit rst,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit hp, input bit vp, input int cd, input int rl, input int ss);
    exp_t x;
    int ht, fr, kt, p, px, py, q, qx, qy;
    ht = ha + hfp + hsw + hbp;
    fr = ht * (va + vfp + vsw + vbp);
    x.chk_rgb = 1'b1; x.chk_req = 1'b0;
    x.r = 8'h0; x.g = 8'h0; x.b = 8'h0;
    x.blank = 1'b0; x.hs = ~hp; x.vs = ~vp; x.vclk = 1'b0;
    x.ls = 1'b0; x.fs = 1'b0; x.rv = 1'b0; x.rx = 0; x.ry = 0;
    if (rst) return x;
    x.vclk = ((e + 1) % cd) >= (cd / 2);
    q  = (e / cd + rl) % fr;
    qx = q % ht; qy = q / ht;
    x.chk_req = 1'b1;
    x.rv = (qx < ha) && (qy < va);
    x.rx = x.rv ? (qx >> ss) : 0;
    x.ry = x.rv ? (qy >> ss) : 0;
    if (e >= cd - 1) begin
      kt = (e + 1) / cd - 1;
      p  = kt % fr;
      px = p % ht; py = p / ht;
      x.blank = (px < ha) && (py < va);
      if (x.blank) begin
        x.r = 8'((px >> ss) & 255);
        x.g = 8'((py >> ss) & 255);
        x.b = 8'h55;
      end
      // The first READ_LATENCY pixels after reset were never requested.
      x.chk_rgb = (kt >= rl);
      x.hs = (px >= ha + hfp && px < ha + hfp + hsw) ? hp : ~hp;
      x.vs = (py >= va + vfp && py < va + vfp + vsw) ? vp : ~vp;
      if (e % cd == cd - 1) begin
        x.ls = ((kt + 1) % ht) == 0;
        x.fs = ((kt + 1) % fr) == 0;
      end
    end
    return x;
  endfunction

  // ---------------- instance A ----------------
  vga_scanout_if #(.XW($clog2(A_HA)), .YW($clog2(A_VA))) pa ();
  logic [7:0] a_r, a_g, a_b;
  logic a_clk, a_hs, a_vs, a_bn, a_sn, a_fs, a_ls;
  logic [23:0] a_pipe [A_N];
  exp_t qa [$];
  exp_t xa;
  int e_a = 0, a_fs_n = 0, a_ls_n = 0;

  vga_scanout #(
    .HACTIVE(A_HA), .HFP(A_HFP), .HSYNC(A_HS), .HBP(A_HBP),
    .VACTIVE(A_VA), .VFP(A_VFP), .VSYNC(A_VS), .VBP(A_VBP),
    .HS_POL(A_HP), .VS_POL(A_VP), .CLKDIV(A_CD), .READ_LATENCY(A_RL), .SCALE_SHIFT(A_SS)
  ) dut_a (
    .clk50(clk50), .reset(reset), .pix(pa),
    .frame_start(a_fs), .line_start(a_ls),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_CLK(a_clk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_n(a_bn), .VGA_SYNC_n(a_sn)
  );

  // Pixel source with a fixed read latency: r=x, g=y, b=0x55.
  always @(posedge clk50) begin
    a_pipe[0] <= {8'(pa.request_x), 8'(pa.request_y), 8'h55};
    for (int i = 1; i < A_N; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign {pa.r, pa.g, pa.b} = a_pipe[A_N-1];

  always @(posedge clk50) begin
    if (reset) begin
      qa.push_back(model(0, 1'b1, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_HP, A_VP, A_CD, A_RL, A_SS));
      e_a <= 0;
    end else begin
      qa.push_back(model(e_a, 1'b0, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_HP, A_VP, A_CD, A_RL, A_SS));
      e_a <= e_a + 1;
    end
  end

  always @(negedge clk50) begin
    if (qa.size() > 0) begin
      xa = qa.pop_front();
      if (xa.chk_rgb) check("A.rgb", {a_r, a_g, a_b}, {xa.r, xa.g, xa.b});
      check("A.ctl", {a_bn, a_hs, a_vs, a_sn, a_clk}, {xa.blank, xa.hs, xa.vs, 1'b1, xa.vclk});
      check("A.strobe", {a_ls, a_fs}, {xa.ls, xa.fs});
      if (xa.chk_req)
        check("A.req", {pa.request_valid, 16'(pa.request_x), 16'(pa.request_y)},
                       {xa.rv, 16'(xa.rx), 16'(xa.ry)});
      if (a_fs) a_fs_n++;
      if (a_ls) a_ls_n++;
    end
  end

  // ---------------- instance B ----------------
  vga_scanout_if #(.XW($clog2(B_HA)), .YW($clog2(B_VA))) pb ();
  logic [7:0] b_r, b_g, b_b;
  logic b_clk, b_hs, b_vs, b_bn, b_sn, b_fs, b_ls;
  logic [23:0] b_pipe [B_N];
  exp_t qb [$];
  exp_t xb;
  int e_b = 0, b_fs_n = 0, b_ls_n = 0;

  vga_scanout #(
    .HACTIVE(B_HA), .HFP(B_HFP), .HSYNC(B_HS), .HBP(B_HBP),
    .VACTIVE(B_VA), .VFP(B_VFP), .VSYNC(B_VS), .VBP(B_VBP),
    .HS_POL(B_HP), .VS_POL(B_VP), .CLKDIV(B_CD), .READ_LATENCY(B_RL), .SCALE_SHIFT(B_SS)
  ) dut_b (
    .clk50(clk50), .reset(reset), .pix(pb),
    .frame_start(b_fs), .line_start(b_ls),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_CLK(b_clk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_n(b_bn), .VGA_SYNC_n(b_sn)
  );

  always @(posedge clk50) begin
    b_pipe[0] <= {8'(pb.request_x), 8'(pb.request_y), 8'h55};
    for (int i = 1; i < B_N; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign {pb.r, pb.g, pb.b} = b_pipe[B_N-1];

  always @(posedge clk50) begin
    if (reset) begin
      qb.push_back(model(0, 1'b1, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_HP, B_VP, B_CD, B_RL, B_SS));
      e_b <= 0;
    end else begin
      qb.push_back(model(e_b, 1'b0, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_HP, B_VP, B_CD, B_RL, B_SS));
      e_b <= e_b + 1;
    end
  end

  always @(negedge clk50) begin
    if (qb.size() > 0) begin
      xb = qb.pop_front();
      if (xb.chk_rgb) check("B.rgb", {b_r, b_g, b_b}, {xb.r, xb.g, xb.b});
      check("B.ctl", {b_bn, b_hs, b_vs, b_sn, b_clk}, {xb.blank, xb.hs, xb.vs, 1'b1, xb.vclk});
      check("B.strobe", {b_ls, b_fs}, {xb.ls, xb.fs});
      if (xb.chk_req)
        check("B.req", {pb.request_valid, 16'(pb.request_x), 16'(pb.request_y)},
                       {xb.rv, 16'(xb.rx), 16'(xb.ry)});
      if (b_fs) b_fs_n++;
      if (b_ls) b_ls_n++;
    end
  end

  // ---------------- sequence ----------------
  int run_len;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    #1 reset = 1'b0;
    for (int run = 0; run < 2; run++) begin
      // First run stops at an arbitrary mid-frame point before the reset pulse.
      run_len = (run == 0) ? 1500 + int'($urandom_range(0, 400)) : 2400;
      a_fs_n = 0; a_ls_n = 0; b_fs_n = 0; b_ls_n = 0;
      repeat (run_len) @(negedge clk50);
      #1;
      check("A.frames", 64'(a_fs_n), 64'(run_len / (A_FR * A_CD)));
      check("A.lines",  64'(a_ls_n), 64'(run_len / (A_HT * A_CD)));
      check("B.frames", 64'(b_fs_n), 64'(run_len / (B_FR * B_CD)));
      check("B.lines",  64'(b_ls_n), 64'(run_len / (B_HT * B_CD)));
      reset = 1'b1;
      @(negedge clk50);
      #1 reset = 1'b0;
    end
    repeat (3) @(negedge clk50);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
